// File: rtl/hazard_control_if.sv
// ---------------------------------------------------------------------------
// hazard_control_if
//
// Bundle between the 5-stage pipeline datapath and the hazard control unit.
//
// Pipeline -> unit (hazard sources):
//   IF_ID_RegisterRs1/Rs2, IF_ID_use_rs1/rs2 : source operands of the ID instr
//   ID_EX_MemRead, ID_EX_RegisterRd          : load / destination of the EX instr
//   EX_redirect, EX_redirect_target          : EX-resolved mispredict and its PC
//   ICACHE_stall, DCACHE_stall               : cache misses in progress
// Unit -> pipeline (controls, same cycle):
//   PC_write, pc_redirect, pc_redirect_target
//   IF_ID_write/flush, ID_EX_write/flush, EX_MEM_write, MEM_WB_write
// Unit -> observers (statistics):
//   stall_cnt, loaduse_cnt, redirect_cnt (saturating, CNT_W bits)
//
// Control contract: a pipeline register with *_write=1 loads its new value on
// the next rising edge, *_write=0 holds it. A *_flush=1 loads a bubble
// instead and wins over *_write. pc_redirect only has meaning while PC_write=1.
// ---------------------------------------------------------------------------
interface hazard_control_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       IF_ID_RegisterRs1;
  logic [4:0]       IF_ID_RegisterRs2;
  logic             IF_ID_use_rs1;
  logic             IF_ID_use_rs2;
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_RegisterRd;
  logic             EX_redirect;
  logic [31:0]      EX_redirect_target;
  logic             ICACHE_stall;
  logic             DCACHE_stall;

  logic             PC_write;
  logic             pc_redirect;
  logic [31:0]      pc_redirect_target;
  logic             IF_ID_write;
  logic             IF_ID_flush;
  logic             ID_EX_write;
  logic             ID_EX_flush;
  logic             EX_MEM_write;
  logic             MEM_WB_write;

  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] loaduse_cnt;
  logic [CNT_W-1:0] redirect_cnt;

  // Pipeline side: raises hazard sources, consumes controls.
  modport master (
    output IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_use_rs1, IF_ID_use_rs2,
    output ID_EX_MemRead, ID_EX_RegisterRd, EX_redirect, EX_redirect_target,
    output ICACHE_stall, DCACHE_stall,
    input  PC_write, pc_redirect, pc_redirect_target,
    input  IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
    input  EX_MEM_write, MEM_WB_write,
    input  stall_cnt, loaduse_cnt, redirect_cnt
  );

  // Hazard control unit side.
  modport slave (
    input  IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_use_rs1, IF_ID_use_rs2,
    input  ID_EX_MemRead, ID_EX_RegisterRd, EX_redirect, EX_redirect_target,
    input  ICACHE_stall, DCACHE_stall,
    output PC_write, pc_redirect, pc_redirect_target,
    output IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush,
    output EX_MEM_write, MEM_WB_write,
    output stall_cnt, loaduse_cnt, redirect_cnt
  );
endinterface

// File: rtl/hazard_control_unit.sv
// ---------------------------------------------------------------------------
// hazard_control_unit
//
// Stall/flush controller for the 5-stage RV32 pipeline. Handles everything
// operand forwarding cannot: load-use bubbles, EX-stage redirects, and
// I-cache / D-cache miss stalls. A redirect that arrives while an I-cache
// miss is outstanding is parked in redir_pc and issued once the miss retires.
//
// Ports:
//   clk       : system clock, all state on the rising edge
//   rst       : synchronous, active-high reset
//   hif       : hazard_control_if.slave (hazard sources in, controls and
//               statistics counters out)
//   state_dbg : current FSM state (0 = RUN, 1 = REDIR_WAIT)
//
// Controls are combinational from the current state and inputs, so they
// take effect in the same cycle the hazard is presented.
// ---------------------------------------------------------------------------
module hazard_control_unit #(
  parameter int CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  hazard_control_if.slave        hif,
  output logic                   state_dbg
);

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, loaduse_cnt_q, redirect_cnt_q;

  logic        load_use;
  logic        inc_loaduse;
  logic        inc_redirect;

  logic        pc_write;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_write;
  logic        id_ex_flush;
  logic        ex_mem_write;
  logic        mem_wb_write;

  // A load in EX whose destination feeds the ID instruction. x0 never
  // creates a dependency because it is hard-wired to zero.
  always_comb begin
    load_use = hif.ID_EX_MemRead && (hif.ID_EX_RegisterRd != 5'd0) &&
               ((hif.IF_ID_use_rs1 && (hif.ID_EX_RegisterRd == hif.IF_ID_RegisterRs1)) ||
                (hif.IF_ID_use_rs2 && (hif.ID_EX_RegisterRd == hif.IF_ID_RegisterRs2)));
  end

  // Next-state and control outputs.
  always_comb begin
    pc_write     = 1'b1;
    pc_redirect  = 1'b0;
    pc_target    = 32'd0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    state_d      = state_q;
    redir_pc_d   = redir_pc_q;
    inc_loaduse  = 1'b0;
    inc_redirect = 1'b0;

    if (rst) begin
      // Hold every register and push bubbles into the front of the pipe.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_write  = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      state_d      = RUN;
      redir_pc_d   = 32'd0;
    end else if (hif.DCACHE_stall) begin
      // A D-cache miss freezes the whole pipe in either state. Any EX
      // redirect is still sitting in EX and will be seen again afterwards,
      // so it is deliberately not counted or latched here.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (hif.EX_redirect && !hif.ICACHE_stall) begin
            // Redirect wins over load-use: the load-use instruction in ID
            // is on the wrong path and is flushed anyway.
            pc_redirect  = 1'b1;
            pc_target    = hif.EX_redirect_target;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            inc_redirect = 1'b1;
          end else if (hif.EX_redirect) begin
            // The fetch unit is busy with a miss and cannot take a new PC;
            // park the target and kill the wrong-path instructions now.
            pc_write     = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            redir_pc_d   = hif.EX_redirect_target;
            state_d      = REDIR_WAIT;
            inc_redirect = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID, bubble into EX; older stages drain.
            // Takes precedence over an I-miss so the bubble is not lost.
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            inc_loaduse = 1'b1;
          end else if (hif.ICACHE_stall) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
          end
        end

        REDIR_WAIT: begin
          // EX and ID hold bubbles here, so EX_redirect and load_use are
          // not possible and are not examined.
          if (hif.ICACHE_stall) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
          end else begin
            // The just-completed fetch is wrong-path; discard it while the
            // parked target is loaded into the PC.
            pc_redirect = 1'b1;
            pc_target   = redir_pc_q;
            if_id_flush = 1'b1;
            state_d     = RUN;
          end
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      redir_pc_q     <= 32'd0;
      stall_cnt_q    <= '0;
      loaduse_cnt_q  <= '0;
      redirect_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      redir_pc_q <= redir_pc_d;
      if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (inc_loaduse && (loaduse_cnt_q != CNT_MAX)) begin
        loaduse_cnt_q <= loaduse_cnt_q + CNT_ONE;
      end
      if (inc_redirect && (redirect_cnt_q != CNT_MAX)) begin
        redirect_cnt_q <= redirect_cnt_q + CNT_ONE;
      end
    end
  end

  assign hif.PC_write           = pc_write;
  assign hif.pc_redirect        = pc_redirect;
  assign hif.pc_redirect_target = pc_target;
  assign hif.IF_ID_write        = if_id_write;
  assign hif.IF_ID_flush        = if_id_flush;
  assign hif.ID_EX_write        = id_ex_write;
  assign hif.ID_EX_flush        = id_ex_flush;
  assign hif.EX_MEM_write       = ex_mem_write;
  assign hif.MEM_WB_write       = mem_wb_write;
  assign hif.stall_cnt          = stall_cnt_q;
  assign hif.loaduse_cnt        = loaduse_cnt_q;
  assign hif.redirect_cnt       = redirect_cnt_q;

  assign state_dbg = (state_q == REDIR_WAIT);

endmodule
